// File: rtl/aes_block_loader.sv
// aes_block_loader
// ----------------
// Upstream feeder for a byte-serial AES-128 core. The host fills a 16-byte
// plaintext buffer and a 16-byte key buffer at its own pace. On start the
// block holds the core in reset for one cycle, then streams the buffers in
// lockstep (one plaintext/key pair per clock) for the core's 16-cycle load
// window. It then counts LATENCY cycles and raises done while the core
// output holds a valid ciphertext.
//
// Parameters
//   LATENCY   cycles from the last streamed pair until ciphertext valid (1..255)
//
// Ports
//   clk       system clock
//   rst       synchronous active-high reset
//   wr_en     host write strobe (honoured only in IDLE or DONE)
//   wr_key    write target: 1 = key buffer, 0 = plaintext buffer
//   wr_data   host write byte
//   start     request encryption (honoured only with both buffers full)
//   pt_full   plaintext buffer holds 16 bytes
//   key_full  key buffer holds 16 bytes
//   core_rst  active-high reset to the AES core
//   pt_byte   plaintext byte to the core data input (0x00 outside STREAM)
//   key_byte  key byte to the core key input (0x00 outside STREAM)
//   busy      PRIME, STREAM or WAIT in progress
//   done      level; ciphertext on the core output is valid
//
// All outputs are registers or decodes of registers only.

module aes_block_loader #(
    parameter int LATENCY = 160
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_en,
    input  logic       wr_key,
    input  logic [7:0] wr_data,
    input  logic       start,
    output logic       pt_full,
    output logic       key_full,
    output logic       core_rst,
    output logic [7:0] pt_byte,
    output logic [7:0] key_byte,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PRIME,
        S_STREAM,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] WAIT_LAST = 8'(LATENCY - 1);

    state_t     state;
    logic [7:0] pt_buf  [16];
    logic [7:0] key_buf [16];
    logic [4:0] pt_cnt;
    logic [4:0] key_cnt;
    logic [3:0] idx;
    logic [7:0] wcnt;

    logic       wr_ok;
    logic       pt_wr;
    logic       key_wr;

    assign pt_full  = (pt_cnt == 5'd16);
    assign key_full = (key_cnt == 5'd16);

    // Host writes land only while the loader is quiescent and the target
    // buffer still has room; a full buffer silently drops further bytes.
    assign wr_ok  = (state == S_IDLE) || (state == S_DONE);
    assign pt_wr  = wr_ok && wr_en && !wr_key && !pt_full;
    assign key_wr = wr_ok && wr_en &&  wr_key && !key_full;

    // Buffer storage carries no reset; its contents are don't-care after rst.
    always_ff @(posedge clk) begin
        if (pt_wr) begin
            pt_buf[pt_cnt[3:0]] <= wr_data;
        end
        if (key_wr) begin
            key_buf[key_cnt[3:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            pt_cnt   <= 5'd0;
            key_cnt  <= 5'd0;
            idx      <= 4'd0;
            wcnt     <= 8'd0;
            core_rst <= 1'b1;
            busy     <= 1'b0;
            done     <= 1'b0;
            pt_byte  <= 8'h00;
            key_byte <= 8'h00;
        end else begin
            if (pt_wr) begin
                pt_cnt <= pt_cnt + 5'd1;
            end
            if (key_wr) begin
                key_cnt <= key_cnt + 5'd1;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    // start is judged on the counts registered before this
                    // cycle, so a same-cycle write cannot complete a buffer.
                    if (start && pt_full && key_full) begin
                        state    <= S_PRIME;
                        core_rst <= 1'b1;
                        busy     <= 1'b1;
                        done     <= 1'b0;
                    end
                end

                S_PRIME: begin
                    // Preload pair 0 so it is on the outputs in STREAM k=0.
                    state    <= S_STREAM;
                    idx      <= 4'd0;
                    core_rst <= 1'b0;
                    pt_byte  <= pt_buf[0];
                    key_byte <= key_buf[0];
                end

                S_STREAM: begin
                    // idx is the pair currently presented; fetch the next one.
                    if (idx == 4'd15) begin
                        state    <= S_WAIT;
                        wcnt     <= 8'd0;
                        pt_byte  <= 8'h00;
                        key_byte <= 8'h00;
                    end else begin
                        idx      <= idx + 4'd1;
                        pt_byte  <= pt_buf[idx + 4'd1];
                        key_byte <= key_buf[idx + 4'd1];
                    end
                end

                S_WAIT: begin
                    if (wcnt == WAIT_LAST) begin
                        state   <= S_DONE;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        // Counts reopen the buffers for the next block; the
                        // byte contents are left in place.
                        pt_cnt  <= 5'd0;
                        key_cnt <= 5'd0;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end

                default: begin
                    state    <= S_IDLE;
                    core_rst <= 1'b1;
                    busy     <= 1'b0;
                    done     <= 1'b0;
                    pt_byte  <= 8'h00;
                    key_byte <= 8'h00;
                end
            endcase
        end
    end

endmodule
